// File: rtl/unique_pool_picker.sv
// Draw-without-replacement index picker over a 2^IDX_W slot pool.
// Define UNIQUE_POOL_FALLBACK_SCAN_EN for bounded retries plus wrap scan.
module unique_pool_picker #(
  parameter int IDX_W     = 3,
  parameter int MAX_TRIES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic [IDX_W-1:0] rnd_num,
  input  logic             release_vld,
  input  logic [IDX_W-1:0] release_idx,
  input  logic             clear,
  output logic [IDX_W-1:0] sel_idx,
  output logic             done,
  output logic             fail,
  output logic             busy,
  output logic             all_selected,
  output logic [IDX_W:0]   used_count
);

  localparam int N = 1 << IDX_W;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    SCAN
  } state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     mask_q, mask_d;
  logic [N-1:0]     set_vec, clr_vec;
  logic             accept;
  logic [IDX_W-1:0] acc_idx;
  logic             fail_d;
  logic             rel_hit;

`ifdef UNIQUE_POOL_FALLBACK_SCAN_EN
  logic [7:0]       try_q, try_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
`endif

  assign busy         = (state_q != IDLE);
  assign all_selected = &mask_q;

  // Next-state: decide acceptance, retries and scan stepping
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    acc_idx = rnd_num;
    fail_d  = 1'b0;
`ifdef UNIQUE_POOL_FALLBACK_SCAN_EN
    try_d   = try_q;
    ptr_d   = ptr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (all_selected) begin
            fail_d = 1'b1;
          end else begin
            state_d = SEARCH;
`ifdef UNIQUE_POOL_FALLBACK_SCAN_EN
            try_d   = 8'd0;
`endif
          end
        end
      end
      SEARCH: begin
        if (!mask_q[rnd_num]) begin
          accept  = 1'b1;
          state_d = IDLE;
        end else begin
`ifdef UNIQUE_POOL_FALLBACK_SCAN_EN
          if (try_q == 8'(MAX_TRIES - 1)) begin
            ptr_d   = rnd_num + IDX_W'(1);
            state_d = SCAN;
          end else begin
            try_d = try_q + 8'd1;
          end
`endif
        end
      end
      SCAN: begin
`ifdef UNIQUE_POOL_FALLBACK_SCAN_EN
        acc_idx = ptr_q;
        if (!mask_q[ptr_q]) begin
          accept  = 1'b1;
          state_d = IDLE;
        end else begin
          ptr_d = ptr_q + IDX_W'(1);
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Mask update: release clears first, an accept set wins on the same bit
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (accept)      set_vec = N'(1) << acc_idx;
    if (release_vld) clr_vec = N'(1) << release_idx;
    mask_d  = (mask_q & ~clr_vec) | set_vec;
    rel_hit = release_vld & mask_q[release_idx];
  end

  // State, mask, counters and output pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mask_q     <= '0;
      sel_idx    <= '0;
      done       <= 1'b0;
      fail       <= 1'b0;
      used_count <= '0;
`ifdef UNIQUE_POOL_FALLBACK_SCAN_EN
      try_q      <= '0;
      ptr_q      <= '0;
`endif
    end else if (clear) begin
      state_q    <= IDLE;
      mask_q     <= '0;
      done       <= 1'b0;
      fail       <= 1'b0;
      used_count <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      done    <= accept;
      fail    <= fail_d;
      if (accept) sel_idx <= acc_idx;
      unique case ({accept, rel_hit})
        2'b10:   used_count <= used_count + 1'b1;
        2'b01:   used_count <= used_count - 1'b1;
        default: used_count <= used_count;
      endcase
`ifdef UNIQUE_POOL_FALLBACK_SCAN_EN
      try_q <= try_d;
      ptr_q <= ptr_d;
`endif
    end
  end

endmodule

// File: tb/tb_unique_pool_picker.sv
// Randomised bench for unique_pool_picker against a slot-array model.
// Directed cases pin the model with literal expectations.
module tb_unique_pool_picker;

  localparam int IDX_W     = 3;
  localparam int MAX_TRIES = 4;
  localparam int N         = 1 << IDX_W;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req;
  logic [IDX_W-1:0] rnd_num;
  logic             release_vld;
  logic [IDX_W-1:0] release_idx;
  logic             clear;
  logic [IDX_W-1:0] sel_idx;
  logic             done;
  logic             fail;
  logic             busy;
  logic             all_selected;
  logic [IDX_W:0]   used_count;

  unique_pool_picker #(
    .IDX_W(IDX_W),
    .MAX_TRIES(MAX_TRIES)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .rnd_num(rnd_num),
    .release_vld(release_vld),
    .release_idx(release_idx),
    .clear(clear),
    .sel_idx(sel_idx),
    .done(done),
    .fail(fail),
    .busy(busy),
    .all_selected(all_selected),
    .used_count(used_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  bit               mdl[N];
  logic [IDX_W-1:0] exp_sel;
  bit               exp_done;
  bit               exp_fail;
  bit               exp_busy;
  int               fq[$];

  function automatic void chk(string nm, longint act, longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic int pop();
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(mdl[i]);
    return c;
  endfunction

  function automatic logic [IDX_W-1:0] pick(input bit want_used);
    int q[$];
    for (int i = 0; i < N; i++) if (mdl[i] == want_used) q.push_back(i);
    if (q.size() == 0) return IDX_W'($urandom);
    return IDX_W'(q[$urandom_range(0, q.size() - 1)]);
  endfunction

  // Cycle compare of every output against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("done", done, exp_done);
      chk("fail", fail, exp_fail);
      chk("busy", busy, exp_busy);
      chk("sel_idx", sel_idx, exp_sel);
      chk("used_count", used_count, pop());
      chk("all_selected", all_selected, pop() == N);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    exp_done = 0;
    exp_fail = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) mdl[i] = 0;
    exp_sel  = '0;
    exp_busy = 0;
  endtask

  task automatic clear_all();
    clear = 1;
    step();
    clear = 0;
    for (int i = 0; i < N; i++) mdl[i] = 0;
    exp_busy = 0;
  endtask

  task automatic idle_cycle();
    bit               rv;
    logic [IDX_W-1:0] ri;
    rv = ($urandom_range(0, 1) == 0);
    ri = pick(1);
    release_vld = rv;
    release_idx = ri;
    step();
    release_vld = 0;
    if (rv) mdl[ri] = 0;
  endtask

  // One request; fq supplies forced rnd values, then random (or stuck)
  task automatic do_draw(input bit stuck, input bit rnd_rel,
                         input int rel_at, input int rel_id,
                         output int lat);
    int               k;
    int               tries;
    bit               scan;
    bit               acc;
    bit               rv;
    logic [IDX_W-1:0] r, ri, ptr, cand;
    k = 0;
    tries = 0;
    scan = 0;
    ptr = '0;
    req = 1;
    rnd_num = IDX_W'($urandom);
    if (pop() == N) begin
      step();
      lat = 1;
      req = 0;
      exp_fail = 1;
      fq.delete();
      return;
    end
    step();
    lat = 1;
    req = 0;
    exp_busy = 1;
    forever begin
      if (k < fq.size()) r = IDX_W'(fq[k]);
      else if (stuck) r = pick(1);
      else r = IDX_W'($urandom);
`ifndef UNIQUE_POOL_FALLBACK_SCAN_EN
      if (k >= 40) r = pick(0);
`endif
      rv = 0;
      ri = '0;
      if (k == rel_at) begin
        rv = 1;
        ri = IDX_W'(rel_id);
      end else if (rnd_rel && $urandom_range(0, 3) == 0) begin
        rv = 1;
        ri = IDX_W'($urandom);
      end
      rnd_num = r;
      release_vld = rv;
      release_idx = ri;
      cand = scan ? ptr : r;
      acc = !mdl[cand];
      step();
      lat++;
      release_vld = 0;
      if (rv) mdl[ri] = 0;
      if (acc) begin
        mdl[cand] = 1;
        exp_sel = cand;
        exp_done = 1;
        exp_busy = 0;
        break;
      end
`ifdef UNIQUE_POOL_FALLBACK_SCAN_EN
      if (scan) ptr = ptr + 1'b1;
      else if (tries == MAX_TRIES - 1) begin
        scan = 1;
        ptr = r + 1'b1;
      end else tries++;
`else
      tries++;
`endif
      k++;
    end
    fq.delete();
  endtask

  task automatic fill_except(input int skip);
    int lat;
    clear_all();
    for (int i = 0; i < N; i++) begin
      if (i != skip) begin
        fq.push_back(i);
        do_draw(0, 0, -1, 0, lat);
      end
    end
  endtask

  initial begin
    int lat;
    int op;
    rst_n = 0;
    req = 0;
    rnd_num = '0;
    release_vld = 0;
    release_idx = '0;
    clear = 0;
    model_reset();
    exp_done = 0;
    exp_fail = 0;
    step();
    step();
    rst_n = 1;
    chk_en = 1;
    chk("rst_used", used_count, 0);
    chk("rst_sel", sel_idx, 0);
    chk("rst_busy", busy, 0);

    // First draw: rnd 5 accepted two edges after req
    fq.push_back(5);
    do_draw(0, 0, -1, 0, lat);
    chk("a_lat", lat, 2);
    chk("a_sel", sel_idx, 5);
    chk("a_done", done, 1);
    chk("a_used", used_count, 1);

    // Fill the pool, then a refused request
    fill_except(-1);
    chk("fill_all", all_selected, 1);
    chk("fill_used", used_count, 8);
    do_draw(0, 0, -1, 0, lat);
    chk("full_fail", fail, 1);
    chk("full_done", done, 0);
    chk("full_busy", busy, 0);
    step();
    chk("fail_pulse", fail, 0);

    // Only slot 4 free, rnd stuck at 0
    fill_except(4);
    fq = '{0, 0, 0, 0, 4};
    do_draw(0, 0, -1, 0, lat);
`ifdef UNIQUE_POOL_FALLBACK_SCAN_EN
    chk("scan_lat", lat, 9);
`else
    chk("search_lat", lat, 6);
`endif
    chk("scan_sel", sel_idx, 4);

    // Release slot 6 in the first SEARCH cycle, then draw 6
    fill_except(2);
    fq = '{0, 6};
    do_draw(0, 0, 0, 6, lat);
    chk("rel_sel", sel_idx, 6);
    chk("rel_used", used_count, 7);
    fq.push_back(2);
    do_draw(0, 0, -1, 0, lat);
    chk("rel_slot2", sel_idx, 2);

    // Clear while a draw is stuck on taken slots
    fill_except(4);
    req = 1;
    rnd_num = '0;
    step();
    req = 0;
    exp_busy = 1;
    repeat (5) step();
    clear_all();
    chk("clr_used", used_count, 0);
    chk("clr_busy", busy, 0);
    chk("clr_done", done, 0);
    step();
    chk("clr_nodone", done, 0);
    fq.push_back(3);
    do_draw(0, 0, -1, 0, lat);
    chk("clr_sel", sel_idx, 3);

    // Reset mid-SEARCH with req held
    clear_all();
    fq.push_back(0);
    do_draw(0, 0, -1, 0, lat);
    req = 1;
    rnd_num = '0;
    step();
    req = 0;
    exp_busy = 1;
    step();
    rst_n = 0;
    req = 1;
    step();
    model_reset();
    chk("rst2_busy", busy, 0);
    chk("rst2_used", used_count, 0);
    chk("rst2_sel", sel_idx, 0);
    step();
    rst_n = 1;
    req = 0;
    step();
    chk("rst2_idle", busy, 0);

    // Random mix of draws, releases and clears
    for (int it = 0; it < 300; it++) begin
      op = $urandom_range(0, 19);
      if (op == 0) clear_all();
      else if (op < 8) idle_cycle();
      else do_draw($urandom_range(0, 2) == 0, 1, -1, 0, lat);
    end
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
